reaction_timer_unit: RTL and testbench

REACTION_TIMER_UNIT -- requirements
Module: reaction_timer_unit

---
 rtl/reaction_timer_unit.sv | 90 +++++++++
 tb/tb_reaction_timer_unit.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reaction_timer_unit.sv
// Reaction timer and game timer driven from a shared 1 ms prescaler.
// The reaction timer counts milliseconds up or down with saturation; the game
// timer counts elapsed seconds up to GAME_SECONDS while its enable is held.
module reaction_timer_unit #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int MAX_MS       = 2047,
  parameter int GAME_SECONDS = 60
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        timer_clear,
  input  logic        up,
  input  logic        enable,
  input  logic [10:0] load_value,
  input  logic        game_reset,
  input  logic        game_timer_enable,
  output logic [10:0] timer_value,
  output logic [5:0]  game_timer_value,
  output logic        ms_tick,
  output logic        at_limit,
  output logic        game_over
);

  localparam int              MS_DIV   = CLK_HZ / 1000;
  localparam int              DIV_W    = (MS_DIV > 1) ? $clog2(MS_DIV) : 1;
  localparam logic [DIV_W-1:0] MS_LAST = DIV_W'(MS_DIV - 1);
  localparam logic [10:0]     MAX_V    = 11'(MAX_MS);
  localparam logic [5:0]      GAME_MAX = 6'(GAME_SECONDS);
  localparam logic [9:0]      SEC_LAST = 10'd999;

  logic [DIV_W-1:0] ms_cnt, ms_cnt_nxt;
  logic [9:0]       sec_cnt;
  logic [10:0]      load_sat;

  // Next prescaler count; a clear restarts the millisecond so the first one is full length.
  always_comb begin
    ms_cnt_nxt = ms_cnt + 1'b1;
    if (timer_clear || ms_cnt == MS_LAST) ms_cnt_nxt = '0;
  end

  // ms prescaler; ms_tick is registered so it is high exactly while ms_cnt == MS_LAST.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ms_cnt  <= '0;
      ms_tick <= 1'b0;
    end else begin
      ms_cnt  <= ms_cnt_nxt;
      ms_tick <= (ms_cnt_nxt == MS_LAST);
    end
  end

  assign load_sat = (load_value > MAX_V) ? MAX_V : load_value;

  // Reaction timer: clear/reload first, then a saturating step on each enabled ms.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      timer_value <= '0;
    end else if (timer_clear) begin
      timer_value <= up ? 11'd0 : load_sat;
    end else if (enable && ms_tick) begin
      if (up) begin
        if (timer_value < MAX_V) timer_value <= timer_value + 11'd1;
      end else begin
        if (timer_value != 11'd0) timer_value <= timer_value - 11'd1;
      end
    end
  end

  // Game timer: second prescaler pauses with the enable and freezes once game_over.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_cnt          <= '0;
      game_timer_value <= '0;
    end else if (game_reset) begin
      sec_cnt          <= '0;
      game_timer_value <= '0;
    end else if (game_timer_enable && ms_tick && !game_over) begin
      if (sec_cnt == SEC_LAST) begin
        sec_cnt          <= '0;
        game_timer_value <= game_timer_value + 6'd1;
      end else begin
        sec_cnt <= sec_cnt + 10'd1;
      end
    end
  end

  assign at_limit  = up ? (timer_value == MAX_V) : (timer_value == 11'd0);
  assign game_over = (game_timer_value == GAME_MAX);

endmodule

// File: tb/tb_reaction_timer_unit.sv
// Bench for reaction_timer_unit: 4 cycles per ms, short game so the run stays small.
module tb_reaction_timer_unit;

  localparam int CLK_HZ = 4000;
  localparam int DIV    = CLK_HZ / 1000;
  localparam int MAXMS  = 2047;
  localparam int GS     = 4;

  logic        clk;
  logic        reset_n;
  logic        timer_clear;
  logic        up;
  logic        enable;
  logic [10:0] load_value;
  logic        game_reset;
  logic        game_timer_enable;
  logic [10:0] timer_value;
  logic [5:0]  game_timer_value;
  logic        ms_tick;
  logic        at_limit;
  logic        game_over;

  int checks = 0;
  int errors = 0;
  int cyc_n  = 0;

  // Reference model: time position inside the current ms, ms count inside the current second.
  int m_ph, m_tv, m_gms, m_gtv;

  reaction_timer_unit #(.CLK_HZ(CLK_HZ), .MAX_MS(MAXMS), .GAME_SECONDS(GS)) dut (
    .clk(clk), .reset_n(reset_n), .timer_clear(timer_clear), .up(up), .enable(enable),
    .load_value(load_value), .game_reset(game_reset), .game_timer_enable(game_timer_enable),
    .timer_value(timer_value), .game_timer_value(game_timer_value), .ms_tick(ms_tick),
    .at_limit(at_limit), .game_over(game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_ph = 0; m_tv = 0; m_gms = 0; m_gtv = 0;
  endtask

  // One rising edge of behaviour, using the inputs as driven for this cycle.
  task automatic model_step();
    bit tk;
    tk = (m_ph == DIV - 1);
    if (timer_clear)
      m_tv = up ? 0 : ((int'(load_value) > MAXMS) ? MAXMS : int'(load_value));
    else if (enable && tk)
      m_tv = up ? ((m_tv + 1 > MAXMS) ? MAXMS : m_tv + 1) : ((m_tv - 1 < 0) ? 0 : m_tv - 1);
    if (game_reset) begin
      m_gms = 0; m_gtv = 0;
    end else if (game_timer_enable && tk && m_gtv < GS) begin
      m_gms++;
      if (m_gms == 1000) begin m_gms = 0; m_gtv++; end
    end
    m_ph = timer_clear ? 0 : (m_ph + 1) % DIV;
  endtask

  function automatic logic [19:0] exp_vec();
    logic al;
    al = up ? (m_tv == MAXMS) : (m_tv == 0);
    return {11'(m_tv), 6'(m_gtv), (m_ph == DIV - 1), al, (m_gtv == GS)};
  endfunction

  // Advance one clock; returns at the following falling edge where outputs are sampled.
  task automatic cyc();
    @(posedge clk);
    model_step();
    cyc_n++;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    timer_clear = 0; enable = 0; game_reset = 0; game_timer_enable = 0;
    up = 1; load_value = 0;
  endtask

  task automatic test_reset();
    logic [19:0] act;
    act = {timer_value, game_timer_value, ms_tick, at_limit, game_over};
    checks++;
    if (act !== 20'd0) begin
      errors++; $display("FAIL reset_state got %h want 00000", act);
    end
    reset_n = 1;
    // No spurious tick right after release; first tick follows the third edge.
    for (int i = 1; i <= 4; i++) begin
      cyc();
      checks++;
      if (ms_tick !== (i == 3)) begin
        errors++; $display("FAIL reset_release_tick cycle %0d got %b want %b", i, ms_tick, i == 3);
      end
    end
  endtask

  task automatic test_up_count();
    logic [19:0] act;
    int ticks;
    up = 1; timer_clear = 1; cyc(); timer_clear = 0;
    enable = 1; ticks = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      act = {timer_value, game_timer_value, ms_tick, at_limit, game_over};
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL up_count cycle %0d got %h want %h", i, act, exp_vec());
      end
      if (ms_tick) ticks++;
    end
    checks++;
    if (timer_value !== 11'd10 || ticks != 10) begin
      errors++; $display("FAIL up_count_final got tv=%0d ticks=%0d want tv=10 ticks=10", timer_value, ticks);
    end
    enable = 0;
  endtask

  task automatic test_sat_up();
    logic [19:0] act;
    up = 1; timer_clear = 1; cyc(); timer_clear = 0; enable = 1;
    for (int i = 0; i < 2050 * DIV; i++) begin
      cyc();
      act = {timer_value, game_timer_value, ms_tick, at_limit, game_over};
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL sat_up cycle %0d got %h want %h", i, act, exp_vec());
      end
    end
    checks++;
    if (timer_value !== 11'd2047 || at_limit !== 1'b1) begin
      errors++; $display("FAIL sat_up_final got tv=%0d lim=%b want tv=2047 lim=1", timer_value, at_limit);
    end
    enable = 0;
  endtask

  task automatic test_sat_down();
    int want [5] = '{2, 1, 0, 0, 0};
    up = 0; load_value = 3; timer_clear = 1; cyc(); timer_clear = 0;
    checks++;
    if (timer_value !== 11'd3 || at_limit !== 1'b0) begin
      errors++; $display("FAIL sat_down_load got tv=%0d lim=%b want tv=3 lim=0", timer_value, at_limit);
    end
    enable = 1;
    for (int k = 0; k < 5; k++) begin
      repeat (DIV) cyc();
      checks++;
      if (timer_value !== 11'(want[k]) || at_limit !== (want[k] == 0)) begin
        errors++; $display("FAIL sat_down ms %0d got tv=%0d lim=%b want tv=%0d lim=%b",
                           k + 1, timer_value, at_limit, want[k], want[k] == 0);
      end
    end
    enable = 0;
  endtask

  task automatic test_priority();
    int waited;
    up = 0; load_value = 100; timer_clear = 1; cyc(); timer_clear = 0; enable = 1;
    waited = 0;
    while (!ms_tick && waited < 2 * DIV) begin cyc(); waited++; end
    checks++;
    if (!ms_tick) begin
      errors++; $display("FAIL priority_wait_tick got no tick want tick within %0d cycles", 2 * DIV);
    end
    timer_clear = 1; load_value = 2000; cyc(); timer_clear = 0;
    checks++;
    if (timer_value !== 11'd2000) begin
      errors++; $display("FAIL priority_clear got %0d want 2000", timer_value);
    end
    cyc();
    checks++;
    if (timer_value !== 11'd2000 || timer_value !== 11'(m_tv)) begin
      errors++; $display("FAIL priority_hold got %0d want 2000", timer_value);
    end
    enable = 0;
  endtask

  task automatic test_game();
    int last, prev, steps, waited;
    timer_clear = 1; game_reset = 1; cyc(); timer_clear = 0; game_reset = 0;
    game_timer_enable = 1;
    last = cyc_n; prev = 0; steps = 0;
    for (int n = 0; n < (GS + 1) * 1000 * DIV; n++) begin
      cyc();
      if (int'(game_timer_value) != prev) begin
        checks++;
        if (cyc_n - last != 1000 * DIV || int'(game_timer_value) != prev + 1) begin
          errors++; $display("FAIL game_step got val=%0d after %0d cycles want val=%0d after %0d",
                             game_timer_value, cyc_n - last, prev + 1, 1000 * DIV);
        end
        last = cyc_n; prev = int'(game_timer_value); steps++;
      end
    end
    checks++;
    if (game_timer_value !== 6'(GS) || game_over !== 1'b1 || steps != GS ||
        game_timer_value !== 6'(m_gtv)) begin
      errors++; $display("FAIL game_final got val=%0d over=%b steps=%0d want val=%0d over=1 steps=%0d",
                         game_timer_value, game_over, steps, GS, GS);
    end
    // Pause for 1000 cycles half-way through the first second.
    timer_clear = 1; game_reset = 1; cyc(); timer_clear = 0; game_reset = 0;
    checks++;
    if (game_timer_value !== 6'd0 || game_over !== 1'b0) begin
      errors++; $display("FAIL game_reset got val=%0d over=%b want 0 0", game_timer_value, game_over);
    end
    last = cyc_n;
    for (int n = 1; n <= 3000; n++) begin
      game_timer_enable = (n <= 2000);
      cyc();
    end
    game_timer_enable = 1; waited = 0;
    while (game_timer_value == 6'd0 && waited < 3000) begin cyc(); waited++; end
    checks++;
    if (game_timer_value !== 6'd1 || cyc_n - last != 5000) begin
      errors++; $display("FAIL game_pause got val=%0d after %0d cycles want 1 after 5000",
                         game_timer_value, cyc_n - last);
    end
    game_timer_enable = 0;
  endtask

  task automatic test_async_reset();
    logic [19:0] act;
    up = 1; enable = 1; game_timer_enable = 1;
    timer_clear = 1; cyc(); timer_clear = 0;
    repeat (4 * DIV + 2) cyc();
    #2 reset_n = 0;
    #1;
    act = {timer_value, game_timer_value, ms_tick, at_limit, game_over};
    checks++;
    if ({timer_value, game_timer_value, ms_tick} !== 18'd0) begin
      errors++; $display("FAIL async_reset got %h want tv=0 gtv=0 tick=0", act);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1;
    for (int i = 1; i <= 2 * DIV; i++) begin
      cyc();
      act = {timer_value, game_timer_value, ms_tick, at_limit, game_over};
      checks++;
      if (act !== exp_vec() || ms_tick !== ((i % DIV) == 3) || timer_value !== 11'(i / DIV)) begin
        errors++; $display("FAIL async_restart cycle %0d got %h want %h", i, act, exp_vec());
      end
    end
    idle_inputs();
  endtask

  task automatic test_random();
    logic [19:0] act;
    for (int i = 0; i < 6000; i++) begin
      timer_clear       = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 19) == 0) up = ~up;
      enable            = ($urandom_range(0, 7) != 0);
      load_value        = ($urandom_range(0, 1) == 1) ? 11'($urandom_range(0, 5))
                                                      : 11'($urandom_range(0, 2047));
      game_reset        = ($urandom_range(0, 499) == 0);
      game_timer_enable = ($urandom_range(0, 4) != 0);
      cyc();
      act = {timer_value, game_timer_value, ms_tick, at_limit, game_over};
      checks++;
      if (act !== exp_vec()) begin
        errors++; $display("FAIL random cycle %0d got %h want %h", i, act, exp_vec());
      end
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    reset_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    test_reset();
    test_up_count();
    test_sat_up();
    test_sat_down();
    test_priority();
    test_game();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
